// File: rtl/sec_timer_pkg.sv
// Shared definitions for the seconds timer: FSM encoding, BCD digit type and defaults.
package sec_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DIGIT_W       = 4;
  localparam int DEF_TICK_DIV  = 50_000_000;
  localparam int DEF_LIMIT_MIN = 1;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Returns {carry, next digit}; the digit wraps to 0 after reaching top.
  function automatic logic [DIGIT_W:0] bcd_inc(input digit_t d, input digit_t top);
    if (d == top) begin
      return {1'b1, digit_t'(0)};
    end
    return {1'b0, d + digit_t'(1)};
  endfunction

endpackage

// File: rtl/sec_timer_if.sv
// Command and status bundle between the timer and its controller / display stage.
interface sec_timer_if;
  import sec_timer_pkg::*;

  logic        start;
  logic        stop;
  logic        clear;
  logic [15:0] text;
  logic        sec_tick;
  logic        running;
  logic        expired;
  logic        done;

  modport master (
    output start, stop, clear,
    input  text, sec_tick, running, expired, done
  );

  modport slave (
    input  start, stop, clear,
    output text, sec_tick, running, expired, done
  );

endinterface

// File: rtl/sec_timer_tick_gen.sv
// Prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last one as the tick.
module tick_gen #(
  parameter int C        = 26,
  parameter int TICK_DIV = sec_timer_pkg::DEF_TICK_DIV
) (
  input  logic CLK1,
  input  logic arst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [C-1:0] LAST = C'(TICK_DIV - 1);

  logic [C-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + C'(1);
    end
  end

  always_ff @(posedge CLK1 or negedge arst) begin
    if (!arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sec_timer.sv
// MM:SS stopwatch that counts up to LIMIT_MIN:00 in BCD, with run/pause/clear control.
module sec_timer
  import sec_timer_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int C         = 26,
  parameter int LIMIT_MIN = DEF_LIMIT_MIN
) (
  input  logic         CLK1,
  input  logic         arst,
  sec_timer_if.slave   bus
);

  localparam logic [15:0] LIMIT_TEXT = {DIGIT_W'(LIMIT_MIN / 10), DIGIT_W'(LIMIT_MIN % 10), 8'h00};

  state_e      state_q, state_d;
  logic [15:0] text_q, text_d;
  logic        sec_tick_q, sec_tick_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        done_q, done_d;

  logic        tick;
  logic        c_s1, c_s10, c_m1;
  digit_t      n_s1, n_s10, n_m1, n_m10;
  logic [15:0] text_inc;

  tick_gen #(
    .C        (C),
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK1 (CLK1),
    .arst (arst),
    .en   (state_q == ST_RUN),
    .clr  (bus.clear),
    .tick (tick)
  );

  // BCD carry chain; minutes tens never overflows because the limit is at most 99.
  always_comb begin
    {c_s1,  n_s1}  = bcd_inc(text_q[3:0], digit_t'(9));
    {c_s10, n_s10} = c_s1  ? bcd_inc(text_q[7:4],  digit_t'(5)) : {1'b0, text_q[7:4]};
    {c_m1,  n_m1}  = c_s10 ? bcd_inc(text_q[11:8], digit_t'(9)) : {1'b0, text_q[11:8]};
    n_m10          = c_m1  ? text_q[15:12] + digit_t'(1) : text_q[15:12];
    text_inc       = {n_m10, n_m1, n_s10, n_s1};
  end

  always_comb begin
    state_d = state_q;
    text_d  = text_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      text_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (bus.start && !bus.stop) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A tick coinciding with stop is still counted; expiry outranks the pause.
          if (tick) text_d = text_inc;
          if (tick && (text_inc == LIMIT_TEXT)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (bus.stop) begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    sec_tick_d = tick && !bus.clear;
    running_d  = (state_d == ST_RUN);
    expired_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK1 or negedge arst) begin
    if (!arst) begin
      state_q    <= ST_IDLE;
      text_q     <= '0;
      sec_tick_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      text_q     <= text_d;
      sec_tick_q <= sec_tick_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
      done_q     <= done_d;
    end
  end

  assign bus.text     = text_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.running  = running_q;
  assign bus.expired  = expired_q;
  assign bus.done     = done_q;

endmodule
